// File: rtl/pre_emphasis_mc.sv
// Multi-channel TDM pre-emphasis filter y[n] = x[n] - alpha*x[n-1] with per-channel history,
// frame-start clear, runtime alpha/bypass, round-half-up, saturation and a 2-stage elastic pipe.
module pre_emphasis_mc #(
  parameter  int SAMPLE_WIDTH = 16,
  parameter  int COEF_WIDTH   = 16,
  parameter  int NUM_CH       = 2,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COEF_WIDTH-1:0]   cfg_alpha,
  input  logic                    cfg_bypass,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic                    in_first,
  input  logic [SAMPLE_WIDTH-1:0] x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic                    out_first,
  output logic                    out_sat,
  output logic [SAMPLE_WIDTH-1:0] y_out
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int CW = COEF_WIDTH;
  localparam int PW = SW + CW + 1;

  localparam logic signed [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (CW - 2);
  localparam logic signed [PW-1:0] MAXV = {{(CW+2){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(CW+2){1'b1}}, {(SW-1){1'b0}}};

  // Handshake: the whole pipe advances when the output slot is empty or being taken
  // (adv = !out_valid || out_ready); a sample transfers on in_valid && in_ready, and
  // out_* stay frozen while out_valid && !out_ready.
  logic w_adv;
  logic w_accept;
  logic w_ch_ok;
  logic signed [SW-1:0] w_hist_rd;
  logic signed [SW-1:0] w_prev;
  logic signed [PW-1:0] w_prod;

  logic signed [SW-1:0] r_hist [NUM_CH];

  logic                 r_s1_valid;
  logic signed [SW-1:0] r_s1_x;
  logic signed [PW-1:0] r_s1_prod;
  logic [CH_W-1:0]      r_s1_ch;
  logic                 r_s1_first;
  logic                 r_s1_byp;

  logic signed [PW-1:0] w_round;
  logic signed [PW-1:0] w_scaled;
  logic signed [PW-1:0] w_diff;
  logic [SW-1:0]        w_y;
  logic                 w_sat;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;

  always_comb begin
    w_ch_ok   = 1'b0;
    w_hist_rd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch == CH_W'(c)) begin
        w_ch_ok   = 1'b1;
        w_hist_rd = r_hist[c];
      end
    end
  end

  assign w_prev = in_first ? '0 : w_hist_rd;
  // Signed history times unsigned alpha: zero-extend alpha so it stays non-negative.
  assign w_prod = $signed({{(CW+1){w_prev[SW-1]}}, w_prev}) *
                  $signed({{(SW+1){1'b0}}, cfg_alpha});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) r_hist[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_accept && (in_ch == CH_W'(c))) r_hist[c] <= x_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_prod  <= '0;
      r_s1_ch    <= '0;
      r_s1_first <= 1'b0;
      r_s1_byp   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_x     <= x_in;
        r_s1_prod  <= w_prod;
        r_s1_ch    <= in_ch;
        r_s1_first <= in_first;
        r_s1_byp   <= cfg_bypass || !w_ch_ok;
      end
    end
  end

  // Difference is kept at product width so the clamp sees every bit of the true result.
  assign w_round  = r_s1_prod + RND;
  assign w_scaled = w_round >>> (CW - 1);
  assign w_diff   = $signed({{(CW+1){r_s1_x[SW-1]}}, r_s1_x}) - w_scaled;

  always_comb begin
    w_y   = w_diff[SW-1:0];
    w_sat = 1'b0;
    if (r_s1_byp) begin
      w_y = r_s1_x;
    end else if (w_diff > MAXV) begin
      w_y   = MAXV[SW-1:0];
      w_sat = 1'b1;
    end else if (w_diff < MINV) begin
      w_y   = MINV[SW-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      out_ch    <= '0;
      out_first <= 1'b0;
      out_sat   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        y_out     <= w_y;
        out_ch    <= r_s1_ch;
        out_first <= r_s1_first;
        out_sat   <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_pre_emphasis_mc.sv
// Directed bench for pre_emphasis_mc (3 channels so an out-of-range index is reachable);
// expected outputs are queued at accept time and checked in order at the output port.
module tb_pre_emphasis_mc;

  localparam int SW  = 16;
  localparam int CW  = 16;
  localparam int NC  = 3;
  localparam int CHW = 2;
  localparam int A97 = 31785;
  localparam int AH  = 16384;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [CW-1:0]  cfg_alpha = '0;
  logic           cfg_bypass = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic           in_first = 1'b0;
  logic [SW-1:0]  x_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [CHW-1:0] out_ch;
  logic           out_first;
  logic           out_sat;
  logic [SW-1:0]  y_out;

  logic [19:0] exp_q[$];
  logic [19:0] obs_pkt;
  int n_checks = 0;
  int n_fail   = 0;
  int m_hist [NC];

  pre_emphasis_mc #(.SAMPLE_WIDTH(SW), .COEF_WIDTH(CW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .cfg_alpha(cfg_alpha), .cfg_bypass(cfg_bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_first(in_first),
    .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_first(out_first), .out_sat(out_sat), .y_out(y_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver: hy/hs are hand-computed results, or the small model fills them when use_model=1
  task automatic send(input int ch, input bit first, input int x, input int alpha, input bit byp,
                      input bit use_model, input int hy, input bit hs);
    int y;
    bit sat;
    longint prev, sc, d;
    int n;
    y = hy;
    sat = hs;
    if (use_model) begin
      y = x;
      sat = 1'b0;
      if (!(byp || ch >= NC)) begin
        prev = first ? 0 : longint'(m_hist[ch]);
        sc = (prev * alpha + 16384) >>> 15;
        d = x - sc;
        if (d > 32767) begin d = 32767; sat = 1'b1; end
        if (d < -32768) begin d = -32768; sat = 1'b1; end
        y = int'(d);
      end
    end
    if (ch < NC) m_hist[ch] = x;
    @(negedge clk);
    in_valid   = 1'b1;
    in_ch      = CHW'(ch);
    in_first   = first;
    x_in       = SW'(x);
    cfg_alpha  = CW'(alpha);
    cfg_bypass = byp;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    exp_q.push_back({CHW'(ch), first, sat, SW'(y)});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: compare on transfer, and the head entry stays on the port while stalled
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      obs_pkt = {out_ch, out_first, out_sat, y_out};
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd0, 32'd1);
      end else if (out_ready) begin
        check("out", {12'b0, obs_pkt}, {12'b0, exp_q.pop_front()});
      end else begin
        check("held_out", {12'b0, obs_pkt}, {12'b0, exp_q[0]});
        check("in_ready_stall", {31'b0, in_ready}, 32'd0);
      end
    end
  end

  initial begin
    for (int c = 0; c < NC; c++) m_hist[c] = 0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_y_out", {16'b0, y_out}, 32'd0);
    check("rst_out_sat", {31'b0, out_sat}, 32'd0);
    check("rst_out_ch", {30'b0, out_ch}, 32'd0);
    check("rst_out_first", {31'b0, out_first}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // basic 0.97 emphasis
    send(0, 1, 1000, A97, 0, 0, 1000, 0);
    send(0, 0, 1000, A97, 0, 0, 30, 0);
    // saturation both directions
    send(0, 1, 32767, A97, 0, 0, 32767, 0);
    send(0, 0, -32768, A97, 0, 0, -32768, 1);
    send(0, 0, 32767, A97, 0, 0, 32767, 1);
    // round half toward +inf
    send(0, 1, 3, AH, 0, 0, 3, 0);
    send(0, 0, 0, AH, 0, 0, -2, 0);
    send(0, 1, -3, AH, 0, 0, -3, 0);
    send(0, 0, 0, AH, 0, 0, 1, 0);
    // interleaved channels
    send(0, 1, 1000, A97, 0, 0, 1000, 0);
    send(1, 1, -2000, A97, 0, 0, -2000, 0);
    send(0, 0, 1000, A97, 0, 0, 30, 0);
    send(1, 0, -2000, A97, 0, 0, -60, 0);
    // alpha = 0
    send(2, 1, 500, 0, 0, 0, 500, 0);
    send(2, 0, -700, 0, 0, 0, -700, 0);
    // bypass still records history
    send(0, 1, 200, A97, 1, 0, 200, 0);
    send(0, 0, 200, AH, 0, 0, 100, 0);
    send(0, 0, -5000, A97, 1, 0, -5000, 0);
    send(0, 0, 0, AH, 0, 0, 2500, 0);
    // out-of-range channel passes through untouched
    send(3, 0, 1234, A97, 0, 0, 1234, 0);
    send(0, 0, 4, AH, 0, 0, 4, 0);
    drain();

    // streaming with a 5-cycle output stall
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(i % 3, i < 3, i * 1500 - 12000, A97, 0, 1, 0, 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with samples in flight
    send(0, 1, 700, A97, 0, 0, 700, 0);
    send(1, 1, 800, A97, 0, 0, 800, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_y_out", {16'b0, y_out}, 32'd0);
    exp_q.delete();
    for (int c = 0; c < NC; c++) m_hist[c] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 0, 500, A97, 0, 0, 500, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
